// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the instruction memory address and
// holds the fetched instruction in a one-entry valid/ready slot.
module inst_fetch #(
  parameter int          MEM_SIZE   = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          INST_WIDTH = 32,
  parameter int          AW         = $clog2(MEM_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic [AW-1:0]         o_imem_addr,
  input  logic [INST_WIDTH-1:0] i_imem_inst,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [31:0]           o_pc,
  output logic                  o_fault,
  input  logic                  i_redirect,
  input  logic [31:0]           i_redirect_pc,
  input  logic                  i_halt,
  output logic                  o_halted
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [31:0]           opc_q, opc_d;
  logic                  fault_q, fault_d;
  logic                  load;

  // Target low bits are forced to zero, so they are never read.
  logic unused_rpc_lo;
  assign unused_rpc_lo = ^i_redirect_pc[1:0];

  assign o_imem_addr = pc_q[AW-1:0];
  assign o_valid     = valid_q;
  assign o_inst      = inst_q;
  assign o_pc        = opc_q;
  assign o_fault     = fault_q;
  assign o_halted    = (state_q == HALTED) && !valid_q;

  // A new fetch fills the slot when running and the slot is free.
  assign load = (state_q == RUN) && !i_halt && !i_redirect
              && (!valid_q || i_ready);

  // Next-state logic: redirect beats load, hold and halt.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    opc_d   = opc_q;
    fault_d = fault_q;
    if (i_redirect) begin
      pc_d    = {i_redirect_pc[31:2], 2'b00};
      valid_d = 1'b0;
      state_d = RUN;
    end else begin
      if (load) begin
        inst_d  = i_imem_inst;
        opc_d   = pc_q;
        fault_d = |pc_q[31:AW];
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd4;
      end else if (valid_q && i_ready) begin
        valid_d = 1'b0;
      end
      unique case (state_q)
        RUN:     if (i_halt)  state_d = HALTED;
        HALTED:  if (!i_halt) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // State and slot registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      inst_q  <= '0;
      opc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      opc_q   <= opc_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with literal expectations
// plus a cycle-level reference model compared every cycle.
module tb_inst_fetch;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_inst;
  logic          valid;
  logic          ready;
  logic [31:0]   inst;
  logic [31:0]   pc;
  logic          fault;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          halt;
  logic          halted;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i * 4;
  end

  assign imem_inst = mem[imem_addr[9:2]];

  inst_fetch #(
    .MEM_SIZE(1024),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_imem_addr  (imem_addr),
    .i_imem_inst  (imem_inst),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_inst       (inst),
    .o_pc         (pc),
    .o_fault      (fault),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .i_halt       (halt),
    .o_halted     (halted)
  );

  // Reference model: what the slot must hold after each edge.
  bit          m_started = 0;
  bit          m_running;
  bit          m_valid;
  logic [31:0] m_next;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  bit          m_fault;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + (a & 32'h0000_03FC);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_started = 1;
      m_running = 1;
      m_valid   = 0;
      m_next    = 32'h0;
      m_pc      = 32'h0;
      m_inst    = 32'h0;
      m_fault   = 0;
    end else if (m_started) begin
      if (redirect) begin
        m_valid   = 0;
        m_next    = redirect_pc & 32'hFFFF_FFFC;
        m_running = 1;
      end else begin
        if (m_running && !halt && (!m_valid || ready)) begin
          m_valid = 1;
          m_pc    = m_next;
          m_inst  = mem_word(m_next);
          m_fault = (m_next >= 32'd1024);
          m_next  = m_next + 32'd4;
        end else if (m_valid && ready) begin
          m_valid = 0;
        end
        m_running = !halt;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_started) begin
      n_checks++;
      if (valid !== m_valid || halted !== (!m_running && !m_valid)) begin
        n_fail++;
        $display("FAIL model_ctl t=%0t valid=%b halted=%b required valid=%b halted=%b",
                 $time, valid, halted, m_valid, !m_running && !m_valid);
      end
      if (m_valid) begin
        n_checks++;
        if (pc !== m_pc || inst !== m_inst || fault !== m_fault) begin
          n_fail++;
          $display("FAIL model_slot t=%0t pc=%h inst=%h fault=%b required pc=%h inst=%h fault=%b",
                   $time, pc, inst, fault, m_pc, m_inst, m_fault);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_slot(input string name, input logic [31:0] epc,
                          input logic [31:0] einst, input logic efault);
    chk({name, "_v"}, {31'b0, valid}, 32'd1);
    chk({name, "_pc"}, pc, epc);
    chk({name, "_inst"}, inst, einst);
    chk({name, "_fault"}, {31'b0, fault}, {31'b0, efault});
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    step();
    redirect = 1'b0;
    chk("redir_empty", {31'b0, valid}, 32'd0);
    step();
  endtask

  initial begin
    rst         = 1'b1;
    ready       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    halt        = 1'b0;
    step();
    step();
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_addr", {22'b0, imem_addr}, 32'h0);
    rst = 1'b0;

    step(); chk_slot("s0", 32'h0, 32'hA000_0000, 1'b0);
    step(); chk_slot("s4", 32'h4, 32'hA000_0004, 1'b0);
    step(); chk_slot("s8", 32'h8, 32'hA000_0008, 1'b0);
    step(); chk_slot("sC", 32'hC, 32'hA000_000C, 1'b0);

    do_redirect(32'h8);
    chk_slot("bp_start", 32'h8, 32'hA000_0008, 1'b0);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_slot("bp_hold", 32'h8, 32'hA000_0008, 1'b0);
    end
    ready = 1'b1;
    step(); chk_slot("bp_rel", 32'hC, 32'hA000_000C, 1'b0);

    do_redirect(32'h102);
    chk_slot("rd100", 32'h100, 32'hA000_0100, 1'b0);
    step(); chk_slot("rd104", 32'h104, 32'hA000_0104, 1'b0);

    do_redirect(32'h400);
    chk_slot("f400", 32'h400, 32'hA000_0000, 1'b1);
    step(); chk_slot("f404", 32'h404, 32'hA000_0004, 1'b1);

    halt = 1'b1;
    step();
    chk("h1_valid", {31'b0, valid}, 32'd0);
    chk("h1_halted", {31'b0, halted}, 32'd1);
    step();
    chk("h2_valid", {31'b0, valid}, 32'd0);
    chk("h2_halted", {31'b0, halted}, 32'd1);
    halt = 1'b0;
    step();
    chk("h3_halted", {31'b0, halted}, 32'd0);
    step(); chk_slot("h_res", 32'h408, 32'hA000_0008, 1'b1);

    do_redirect(32'hFFFF_FFFC);
    chk_slot("wrapA", 32'hFFFF_FFFC, 32'hA000_03FC, 1'b1);
    step(); chk_slot("wrapB", 32'h0, 32'hA000_0000, 1'b0);

    do_redirect(32'h8);
    step();
    step(); chk_slot("mr10", 32'h10, 32'hA000_0010, 1'b0);
    rst = 1'b1;
    step();
    chk("mr_valid", {31'b0, valid}, 32'd0);
    rst = 1'b0;
    step(); chk_slot("mr0", 32'h0, 32'hA000_0000, 1'b0);
    step(); chk_slot("mr4", 32'h4, 32'hA000_0004, 1'b0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL take parameter MEM_SIZE, default 1024, giving the instruction memory size in bytes; AW = $clog2(MEM_SIZE).
REQ-002 The block SHALL take parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port o_imem_addr, output, AW bits: byte address to inst_mem i_addr.
REQ-006 The block SHALL have port i_imem_inst, input, INST_WIDTH bits: combinational read data from inst_mem o_inst.
REQ-007 The block SHALL have port o_valid, output, 1 bit: the output slot holds an instruction.
REQ-008 The block SHALL have port i_ready, input, 1 bit: the decode stage accepts the slot this cycle.
REQ-009 The block SHALL have port o_inst, output, INST_WIDTH bits: the fetched instruction.
REQ-010 The block SHALL have port o_pc, output, 32 bits: the address of o_inst.
REQ-011 The block SHALL have port o_fault, output, 1 bit: the o_pc of the slot is outside memory.
REQ-012 The block SHALL have ports i_redirect (1 bit) and i_redirect_pc (32 bits), inputs: branch/jump target request.
REQ-013 The block SHALL have port i_halt, input, 1 bit: stop issuing new fetches.
REQ-014 The block SHALL have port o_halted, output, 1 bit: in HALTED state with an empty slot.

Function
REQ-015 The block SHALL keep a 32-bit pc register and drive o_imem_addr = pc[AW-1:0] combinationally; memory wraps modulo MEM_SIZE.
REQ-016 The block SHALL load the slot (o_inst <= i_imem_inst, o_pc <= pc, o_fault <= |pc[31:AW], o_valid <= 1, pc <= pc+4) on a cycle where state = RUN and (!o_valid || i_ready) and !i_redirect, giving 1-cycle latency from pc to o_valid.
REQ-017 The block SHALL hold o_valid, o_inst, o_pc and o_fault stable while o_valid && !i_ready; pc SHALL NOT advance.
REQ-018 The block SHALL clear the slot after a transfer (o_valid && i_ready) when no new load occurs in the same cycle.
REQ-019 The block SHALL, on i_redirect, set pc <= {i_redirect_pc[31:2], 2'b00} and o_valid <= 0 next cycle, discarding any slot content; redirect has priority over load, hold and halt.
REQ-020 The block SHALL sustain one instruction per cycle when i_ready is held high.
REQ-021 The block SHALL implement states RUN and HALTED: RUN -> HALTED when i_halt = 1 and no redirect, with no load in that cycle; HALTED -> RUN when i_halt = 0 or i_redirect = 1.
REQ-022 The block SHALL keep holding an unaccepted slot in HALTED until it is accepted or a redirect occurs.
REQ-023 The block SHALL assert o_halted = (state = HALTED) && !o_valid.
REQ-024 The block SHALL compute pc+4 modulo 2^32; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-025 The block SHALL still load a faulting address (o_fault = 1, o_inst = memory data at the wrapped address) and SHALL NOT stall on a fault.

Reset
REQ-026 The block SHALL, while i_rst = 1 at a clock edge, set pc = RESET_PC, state = RUN, o_valid = 0, o_inst = 0, o_pc = 0, o_fault = 0; reset overrides redirect and halt.
REQ-027 The block SHALL make the first load on the first edge with i_rst = 0, so o_valid = 1 with o_pc = RESET_PC one cycle after reset release.
REQ-028 The block SHALL, on reset mid-stream, discard the slot and restart from RESET_PC.

Verification
REQ-029 The bench SHALL instantiate inst_mem (MEM_SIZE 1024) preloaded so that the word at byte address a is 32'hA000_0000 + a.
REQ-030 The bench SHALL cover streaming: reset release with i_ready = 1 -> o_pc 0x0, 0x4, 0x8, 0xC on consecutive cycles with o_inst A0000000, A0000004, A0000008, A000000C.
REQ-031 The bench SHALL cover backpressure: i_ready = 0 for 3 cycles while o_pc = 0x8 -> o_pc/o_inst held at 0x8/A0000008, then 0xC on the cycle after i_ready = 1.
REQ-032 The bench SHALL cover redirect: i_redirect = 1, i_redirect_pc = 0x102 while o_valid = 1 -> next cycle o_valid = 0, following cycle o_pc = 0x100, o_inst = A0000100.
REQ-033 The bench SHALL cover fault: redirect to 0x400 -> o_pc = 0x400, o_fault = 1, o_inst = A0000000; next o_pc = 0x404, o_fault = 1.
REQ-034 The bench SHALL cover halt: i_halt = 1 with i_ready = 1 -> o_halted = 1 within 2 cycles, o_valid stays 0; i_halt = 0 -> fetch resumes at the next sequential pc.
REQ-035 The bench SHALL cover mid-stream reset: i_rst = 1 for 1 cycle at o_pc = 0x10 -> o_valid = 0, then o_pc = RESET_PC (0x0).
